// File: rtl/tsc_pkg.sv
// Shared types and constants for the TSC sample capture block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tsc_pkg;

    localparam int DATA_W       = 12;
    // Minimum cycles adc_req stays high before a capture may be taken.
    localparam int REQ_MIN_HIGH = 3;
    // Minimum cycles adc_req stays low between two requests.
    localparam int REQ_MIN_LOW  = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        POST  = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_e;

endpackage

// File: rtl/tsc_req_seq.sv
// ADC request sequencer: paces adc_req, synchronizes adc_rdy and reports each captured sample.
// Latency: capture no earlier than REQ_MIN_HIGH cycles after req rises; sample_valid/timeout are single-cycle pulses.
// Backpressure: none toward the core; the ADC is throttled by SAMPLE_DIV spacing and its own rdy.
module tsc_req_seq #(
    parameter int DATA_W     = tsc_pkg::DATA_W,
    parameter int SAMPLE_DIV = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              active,
    input  logic              adc_rdy,
    input  logic [DATA_W-1:0] adc_dat,
    output logic              adc_req,
    output logic              sample_valid,
    output logic [DATA_W-1:0] sample_data,
    output logic              timeout
);
    import tsc_pkg::*;

    // cnt counts cycles since the last req rise; it must reach both the
    // period and one past the timeout, then saturates.
    localparam int CNT_MAX = (SAMPLE_DIV > TIMEOUT + 1) ? SAMPLE_DIV : TIMEOUT + 1;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int LW      = $clog2(REQ_MIN_LOW + 1);

    localparam logic [CW-1:0] CNT_SAT = CW'(CNT_MAX);
    localparam logic [CW-1:0] DIV_C   = CW'(SAMPLE_DIV);
    localparam logic [CW-1:0] HIGH_C  = CW'(REQ_MIN_HIGH);
    localparam logic [CW-1:0] TO_C    = CW'(TIMEOUT);
    localparam logic [LW-1:0] LOW_C   = LW'(REQ_MIN_LOW);

    logic          rdy_meta_q;
    logic          rdy_s_q;
    logic          req_q, req_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] low_q, low_d;
    logic          capture;
    logic          expire;

    // two-flop synchronizer for the ADC ready, which is asynchronous to clk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_meta_q <= 1'b0;
            rdy_s_q    <= 1'b0;
        end else begin
            rdy_meta_q <= adc_rdy;
            rdy_s_q    <= rdy_meta_q;
        end
    end

    // The minimum high time also masks a rdy still high from the previous sample.
    assign capture = active && req_q && rdy_s_q && (cnt_q >= HIGH_C) && (cnt_q <= TO_C);
    assign expire  = active && req_q && (cnt_q > TO_C);

    // request pacing: rise on period and low-time, fall on capture, timeout or disarm
    always_comb begin
        req_d = req_q;
        cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);
        low_d = (low_q == LOW_C) ? low_q : low_q + LW'(1);
        if (req_q) begin
            low_d = '0;
            if (capture || expire || !active) begin
                req_d = 1'b0;
                low_d = LW'(1);
            end
        end else if (active && (cnt_q >= DIV_C) && (low_q >= LOW_C)) begin
            // A late capture pushes the rise out via the low-time counter.
            req_d = 1'b1;
            cnt_d = CW'(1);
        end
    end

    // request state register; reset drops adc_req immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q <= 1'b0;
            cnt_q <= '0;
            low_q <= '0;
        end else begin
            req_q <= req_d;
            cnt_q <= cnt_d;
            low_q <= low_d;
        end
    end

    // adc_dat is stable while rdy is high, which holds across the capture edge.
    assign adc_req      = req_q;
    assign sample_valid = capture;
    assign sample_data  = adc_dat;
    assign timeout      = expire;

endmodule

// File: rtl/tsc_capture.sv
// Threshold-triggered ADC capture into a circular buffer with pre-trigger history, frozen for readout.
// Latency: a sample lands in the buffer on its capture edge; rd_data is registered, one cycle after rd_addr.
// Backpressure: none; start is ignored while busy and the ADC is paced by the request sequencer.
module tsc_capture #(
    parameter int DATA_W     = tsc_pkg::DATA_W,
    parameter int DEPTH      = 32,
    parameter int PRE_TRIG   = 8,
    parameter int SAMPLE_DIV = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [DATA_W-1:0]        trig_level,
    output logic                     adc_req,
    input  logic                     adc_rdy,
    input  logic [DATA_W-1:0]        adc_dat,
    output logic                     busy,
    output logic                     triggered,
    output logic                     done,
    output logic                     error,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_W-1:0]        rd_data
);
    import tsc_pkg::*;

    localparam int AW  = $clog2(DEPTH);
    localparam int PCW = $clog2(PRE_TRIG + 1);
    localparam int QCW = $clog2(DEPTH - PRE_TRIG + 1);

    localparam logic [PCW-1:0] PRE_C   = PCW'(PRE_TRIG);
    localparam logic [QCW-1:0] POST_C  = QCW'(DEPTH - PRE_TRIG);
    localparam logic [AW-1:0]  PRE_OFF = AW'(PRE_TRIG);

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  lvl_q, lvl_d;
    logic               trig_q, trig_d;
    logic [PCW-1:0]     pre_q, pre_d;
    logic [QCW-1:0]     post_q, post_d;
    logic [AW-1:0]      wptr_q, wptr_d;
    logic [AW-1:0]      tptr_q, tptr_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic [AW-1:0]      rd_idx;
    logic               wr_en;
    logic               active;

    logic               sample_valid;
    logic [DATA_W-1:0]  sample_data;
    logic               timeout;

    logic [DATA_W-1:0]  mem [DEPTH];

    assign active = (state_q == ARMED) || (state_q == POST);

    tsc_req_seq #(
        .DATA_W     (DATA_W),
        .SAMPLE_DIV (SAMPLE_DIV),
        .TIMEOUT    (TIMEOUT)
    ) u_req_seq (
        .clk          (clk),
        .rst          (rst),
        .active       (active),
        .adc_rdy      (adc_rdy),
        .adc_dat      (adc_dat),
        .adc_req      (adc_req),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .timeout      (timeout)
    );

    // capture FSM: arm, fill the ring, detect trigger, count post-samples, freeze
    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        trig_d  = trig_q;
        pre_d   = pre_q;
        post_d  = post_q;
        wptr_d  = wptr_q;
        tptr_d  = tptr_q;
        wr_en   = 1'b0;
        unique case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d = ARMED;
                    lvl_d   = trig_level;
                    trig_d  = 1'b0;
                    pre_d   = '0;
                    post_d  = '0;
                end
            end
            ARMED: begin
                if (timeout) begin
                    state_d = ERROR;
                end else if (sample_valid) begin
                    wr_en  = 1'b1;
                    wptr_d = wptr_q + AW'(1);
                    // Only a sample with a full pre-trigger history behind it may trigger.
                    if ((sample_data >= lvl_q) && (pre_q == PRE_C)) begin
                        trig_d  = 1'b1;
                        tptr_d  = wptr_q;
                        post_d  = QCW'(1);
                        state_d = (POST_C == QCW'(1)) ? DONE : POST;
                    end else if (pre_q != PRE_C) begin
                        pre_d = pre_q + PCW'(1);
                    end
                end
            end
            POST: begin
                if (timeout) begin
                    state_d = ERROR;
                end else if (sample_valid) begin
                    wr_en  = 1'b1;
                    wptr_d = wptr_q + AW'(1);
                    post_d = post_q + QCW'(1);
                    if (post_d == POST_C) begin
                        state_d = DONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lvl_q   <= '0;
            trig_q  <= 1'b0;
            pre_q   <= '0;
            post_q  <= '0;
            wptr_q  <= '0;
            tptr_q  <= '0;
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
            trig_q  <= trig_d;
            pre_q   <= pre_d;
            post_q  <= post_d;
            wptr_q  <= wptr_d;
            tptr_q  <= tptr_d;
        end
    end

    // sample ring buffer; contents are not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr_q] <= sample_data;
        end
    end

    // Logical index 0 is the oldest kept sample, PRE_TRIG entries before the trigger.
    assign rd_idx = tptr_q - PRE_OFF + rd_addr;

    // readout address decode
    always_comb begin
        rd_data_d = mem[rd_idx];
    end

    // registered readout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign busy      = active;
    assign triggered = trig_q;
    assign done      = (state_q == DONE);
    assign error     = (state_q == ERROR);

endmodule

// File: tb/tb_tsc_capture.sv
module tb_tsc_capture;
    localparam int DATA_W     = 12;
    localparam int DEPTH      = 32;
    localparam int PRE_TRIG   = 8;
    localparam int SAMPLE_DIV = 16;
    localparam int TIMEOUT    = 64;
    localparam int POST_N     = DEPTH - PRE_TRIG;
    localparam int REQ_HIGH   = 3;
    localparam int REQ_LOW    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [DATA_W-1:0] trig_level;
    logic              adc_req;
    logic              adc_rdy;
    logic [DATA_W-1:0] adc_dat;
    logic              busy, triggered, done, error;
    logic [4:0]        rd_addr;
    logic [DATA_W-1:0] rd_data;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // ADC model controls
    bit   comb_mode = 1'b0;
    bit   dead      = 1'b0;
    int   dmax      = 0;
    int   adc_idx   = 0;
    logic rdy_model;
    logic [DATA_W-1:0] plan[$];

    // scoreboard
    logic [DATA_W-1:0] exp_q[$];
    logic rd_en  = 1'b0;
    logic rd_vld = 1'b0;

    // handshake monitor state
    int   run_id    = 0;
    int   mon_run   = -1;
    int   rises     = 0;
    int   last_rise = -1;
    int   last_fall = -1;
    logic req_prev  = 1'b0;

    assign adc_rdy = comb_mode ? adc_req : rdy_model;

    tsc_capture #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .PRE_TRIG   (PRE_TRIG),
        .SAMPLE_DIV (SAMPLE_DIV),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .trig_level (trig_level),
        .adc_req    (adc_req),
        .adc_rdy    (adc_rdy),
        .adc_dat    (adc_dat),
        .busy       (busy),
        .triggered  (triggered),
        .done       (done),
        .error      (error),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        rd_vld = rd_en;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: first sample with a full pre-trigger history that meets the level.
    function automatic int find_trig(input logic [DATA_W-1:0] lvl);
        for (int i = PRE_TRIG; i < plan.size(); i++) begin
            if (plan[i] >= lvl) return i;
        end
        return -1;
    endfunction

    // ADC model: new data on each req rise, rdy after a random delay, drop after req falls
    initial begin
        rdy_model = 1'b0;
        adc_dat   = '0;
        forever begin
            wait (adc_req === 1'b1);
            adc_dat = (adc_idx < plan.size()) ? plan[adc_idx] : 12'($urandom_range(0, 4095));
            adc_idx++;
            if (!dead && !comb_mode) begin
                repeat ($urandom_range(0, dmax)) @(posedge clk);
                #1;
                if (adc_req === 1'b1) rdy_model = 1'b1;
            end
            wait (adc_req === 1'b0);
            if (rdy_model) begin
                repeat ($urandom_range(0, 1)) @(posedge clk);
                #1 rdy_model = 1'b0;
            end
        end
    end

    // Handshake timing monitor: next rise = max(prev rise + SAMPLE_DIV, fall + REQ_LOW)
    initial forever begin
        @(negedge clk);
        if (adc_req === 1'b1 && req_prev === 1'b0) begin
            rises++;
            if (mon_run == run_id && last_rise >= 0 && last_fall > last_rise) begin
                int exp_rise;
                exp_rise = (last_rise + SAMPLE_DIV > last_fall + REQ_LOW) ?
                           last_rise + SAMPLE_DIV : last_fall + REQ_LOW;
                chk("req_rise_spacing", cyc - last_rise, exp_rise - last_rise);
            end
            mon_run   = run_id;
            last_rise = cyc;
        end
        if (adc_req === 1'b0 && req_prev === 1'b1) begin
            last_fall = cyc;
            if (comb_mode) chk("req_high_cycles", cyc - last_rise, REQ_HIGH);
        end
        req_prev = adc_req;
    end

    // Scoreboard monitor: compare every registered readout against the queued expectation
    initial forever begin
        @(negedge clk);
        if (rd_vld) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
                logic [DATA_W-1:0] e;
                e = exp_q.pop_front();
                chk("rd_data", rd_data, e);
            end
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        fails++;
        $display("FAIL watchdog: bench still running at cycle %0d, expected completion", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic pulse_start(input logic [DATA_W-1:0] lvl);
        @(posedge clk); #1;
        trig_level = lvl;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        trig_level = 12'($urandom_range(0, 4095));
    endtask

    task automatic build_random(input logic [DATA_W-1:0] lvl, input int len);
        int t;
        plan.delete();
        for (int i = 0; i < len; i++) plan.push_back(12'($urandom_range(0, 4095)));
        t = find_trig(lvl);
        if (t < 0 || t > len - POST_N - 1) plan[len - POST_N - 1] = 12'hFFF;
    endtask

    task automatic do_run(input logic [DATA_W-1:0] lvl, input int dly, input bit comb, input bit poke);
        int t;
        int n;
        t = find_trig(lvl);
        comb_mode = comb;
        dmax      = dly;
        dead      = 1'b0;
        adc_idx   = 0;
        run_id++;
        pulse_start(lvl);
        @(negedge clk);
        chk("busy_after_start", busy, 1);
        chk("triggered_cleared", triggered, 0);
        chk("done_cleared", done, 0);
        if (poke) begin
            // A start while busy must not re-latch the level or restart the count.
            repeat (5) @(posedge clk);
            #1 start = 1'b1; trig_level = '0;
            @(posedge clk);
            #1 start = 1'b0;
        end
        n = 0;
        while (!done && !error && n < 8000) begin
            @(negedge clk);
            n++;
        end
        chk("run_done", done, 1);
        chk("run_no_error", error, 0);
        chk("run_triggered", triggered, 1);
        chk("run_busy_low", busy, 0);
        chk("run_sample_count", adc_idx, t + POST_N);
        repeat (40) @(negedge clk);
        chk("no_req_in_done", adc_idx, t + POST_N);
        chk("req_low_in_done", adc_req, 0);
        for (int j = 0; j < DEPTH + 16; j++) begin
            int a;
            a = (j < DEPTH) ? j : int'($urandom_range(0, DEPTH - 1));
            @(posedge clk); #1;
            rd_addr = 5'(a);
            rd_en   = 1'b1;
            exp_q.push_back(plan[t - PRE_TRIG + a]);
        end
        @(posedge clk); #1 rd_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        int r0;
        logic [DATA_W-1:0] lvl;
        rst        = 1'b1;
        start      = 1'b0;
        trig_level = '0;
        rd_addr    = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk("reset_adc_req", adc_req, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_error", error, 0);
        chk("reset_triggered", triggered, 0);
        chk("reset_rd_data", rd_data, 0);
        @(posedge clk); #1 rst = 1'b0;

        // idle: no requests
        r0 = rises;
        repeat (40) @(negedge clk);
        chk("no_req_idle", rises - r0, 0);

        // reset while ARMED drops everything asynchronously
        dead = 1'b1; adc_idx = 0; run_id++;
        pulse_start(12'hFFF);
        n = 0;
        while (adc_req !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("armed_req_high", adc_req, 1);
        chk("armed_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_req", adc_req, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_error", error, 0);
        @(posedge clk); #1 rst = 1'b0;

        // basic trigger on 0xD7 at sample 10
        plan.delete();
        plan = '{12'h08B, 12'h08C, 12'h099, 12'h09B, 12'h093,
                 12'h082, 12'h097, 12'h090, 12'h09F, 12'h0D7};
        for (int i = 0; i < POST_N + 10; i++) plan.push_back(12'($urandom_range(0, 4095)));
        do_run(12'h0D0, 6, 1'b0, 1'b0);

        // early qualifying samples ignored until the ring is primed
        do_run(12'h080, 4, 1'b0, 1'b0);

        // timeout with rdy held low, then re-arm from ERROR
        dead = 1'b1; comb_mode = 1'b0; adc_idx = 0; run_id++;
        pulse_start(12'h800);
        n = 0;
        while (!error && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_error", error, 1);
        chk("timeout_latency", cyc - last_rise, TIMEOUT + 1);
        chk("timeout_req_low", adc_req, 0);
        chk("timeout_busy_low", busy, 0);
        chk("timeout_single_req", adc_idx, 1);
        lvl = 12'($urandom_range(12'h400, 12'hF00));
        build_random(lvl, 160);
        do_run(lvl, 10, 1'b0, 1'b0);

        // rdy combinational with req: exact handshake timing
        lvl = 12'($urandom_range(12'h800, 12'hFFF));
        build_random(lvl, 160);
        do_run(lvl, 0, 1'b1, 1'b0);

        // 100 pre-trigger samples wrap the ring; trigger exactly at the level
        plan.delete();
        for (int i = 0; i < 99; i++) plan.push_back(12'($urandom_range(0, 12'hBFF)));
        plan.push_back(12'hBFF);
        plan.push_back(12'hC00);
        for (int i = 0; i < POST_N + 10; i++) plan.push_back(12'($urandom_range(0, 4095)));
        do_run(12'hC00, 3, 1'b0, 1'b0);

        // re-arm from DONE with random traffic, including a start while busy
        for (int k = 0; k < 4; k++) begin
            lvl = 12'($urandom_range(12'h600, 12'hFFF));
            build_random(lvl, 160);
            do_run(lvl, int'($urandom_range(0, 20)), 1'b0, (k == 1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
